// File: rtl/mux32_share_arbiter.sv
// Two-requester arbiter that shares one 2:1 mux path and a one-entry output register.
// Define MUX32_ARB_FIXED_PRIORITY_EN to make A win every tie instead of using round-robin.
module mux32_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inAValid,
  input  logic [WIDTH-1:0] inA,
  output logic             inAReady,
  input  logic             inBValid,
  input  logic [WIDTH-1:0] inB,
  output logic             inBReady,
  output logic             sel,
  output logic             outValid,
  output logic [WIDTH-1:0] out,
  input  logic             outReady,
  output logic [CNT_W-1:0] countA,
  output logic [CNT_W-1:0] countB
);

  logic last_grant;
  logic can_accept;
  logic grant_a;
  logic grant_b;
  logic accept;

  // Winner selection; a tie goes to the requester that was not served last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (inAValid && inBValid) begin
`ifdef MUX32_ARB_FIXED_PRIORITY_EN
      grant_a = 1'b1;
`else
      grant_a = last_grant;
      grant_b = !last_grant;
`endif
    end else begin
      grant_a = inAValid;
      grant_b = inBValid;
    end
  end

  // The output stage can take a word when it is empty or being drained this cycle.
  always_comb begin
    can_accept = !outValid || outReady;
    accept     = !Reset && can_accept && (grant_a || grant_b);
    inAReady   = !Reset && can_accept && grant_a;
    inBReady   = !Reset && can_accept && grant_b;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      outValid   <= 1'b0;
      out        <= '0;
      sel        <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      out        <= grant_b ? inB : inA;
      sel        <= grant_b;
      outValid   <= 1'b1;
      last_grant <= grant_b;
    end else if (outReady) begin
      outValid   <= 1'b0;
    end
  end

  // Saturating transfer counters; they only clear on reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      countA <= '0;
      countB <= '0;
    end else begin
      if (inAReady && (countA != {CNT_W{1'b1}})) countA <= countA + CNT_W'(1);
      if (inBReady && (countB != {CNT_W{1'b1}})) countB <= countB + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux32_share_arbiter.sv
// Scoreboard bench for mux32_share_arbiter; a second instance with CNT_W=2 covers saturation.
module tb_mux32_share_arbiter;

  localparam int unsigned WIDTH = 32;

  logic             Clk;
  logic             Reset;
  logic             inAValid;
  logic [WIDTH-1:0] inA;
  logic             inAReady;
  logic             inBValid;
  logic [WIDTH-1:0] inB;
  logic             inBReady;
  logic             sel;
  logic             outValid;
  logic [WIDTH-1:0] out;
  logic             outReady;
  logic [15:0]      countA;
  logic [15:0]      countB;

  logic             s_inAReady;
  logic             s_inBReady;
  logic             s_sel;
  logic             s_outValid;
  logic [WIDTH-1:0] s_out;
  logic [1:0]       s_countA;
  logic [1:0]       s_countB;

  int n_checks;
  int n_pass;
  logic [32:0] sb[$];

  mux32_share_arbiter #(.WIDTH(WIDTH), .CNT_W(16)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .inAValid(inAValid), .inA(inA), .inAReady(inAReady),
    .inBValid(inBValid), .inB(inB), .inBReady(inBReady),
    .sel(sel), .outValid(outValid), .out(out), .outReady(outReady),
    .countA(countA), .countB(countB)
  );

  mux32_share_arbiter #(.WIDTH(WIDTH), .CNT_W(2)) u_dut_sat (
    .Clk(Clk), .Reset(Reset),
    .inAValid(inAValid), .inA(inA), .inAReady(s_inAReady),
    .inBValid(inBValid), .inB(inB), .inBReady(s_inBReady),
    .sel(s_sel), .outValid(s_outValid), .out(s_out), .outReady(outReady),
    .countA(s_countA), .countB(s_countB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Every word the consumer takes must match the oldest expected entry.
  always @(negedge Clk) begin
    if (!Reset && outValid && outReady) begin
      if (sb.size() == 0) check("sb_underflow", 64'(1), 64'(0));
      else check("out_word", 64'({sel, out}), 64'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Reset = 1'b1; inAValid = 1'b0; inA = '0; inBValid = 1'b0; inB = '0; outReady = 1'b0;
    step(); step();

    // Reset state.
    inAValid = 1'b1; inA = 32'h0000_0001;
    @(negedge Clk);
    check("rst_outValid", 64'(outValid), 64'(0));
    check("rst_out", 64'(out), 64'(0));
    check("rst_sel", 64'(sel), 64'(0));
    check("rst_countA", 64'(countA), 64'(0));
    check("rst_countB", 64'(countB), 64'(0));
    check("rst_inAReady", 64'(inAReady), 64'(0));

    // Single A word.
    step();
    Reset = 1'b0; outReady = 1'b1;
    @(negedge Clk);
    check("t1_inAReady", 64'(inAReady), 64'(1));
    check("t1_inBReady", 64'(inBReady), 64'(0));
    sb.push_back({1'b0, 32'h0000_0001});
    step();
    inAValid = 1'b0;
    @(negedge Clk);
    check("t1_outValid", 64'(outValid), 64'(1));
    check("t1_countA", 64'(countA), 64'(1));

    // Both valid for 4 cycles from a fresh reset.
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    inAValid = 1'b1; inA = 32'hF000_0001;
    inBValid = 1'b1; inB = 32'hF000_0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
`ifdef MUX32_ARB_FIXED_PRIORITY_EN
      check("rr_inAReady", 64'(inAReady), 64'(1));
      sb.push_back({1'b0, 32'hF000_0001});
`else
      check("rr_inAReady", 64'(inAReady), 64'((i % 2) == 0));
      check("rr_inBReady", 64'(inBReady), 64'((i % 2) == 1));
      if ((i % 2) == 0) sb.push_back({1'b0, 32'hF000_0001});
      else sb.push_back({1'b1, 32'hF000_0002});
`endif
      step();
    end
    inAValid = 1'b0; inBValid = 1'b0;
    @(negedge Clk);
`ifdef MUX32_ARB_FIXED_PRIORITY_EN
    check("rr_countA", 64'(countA), 64'(4));
    check("rr_countB", 64'(countB), 64'(0));
`else
    check("rr_countA", 64'(countA), 64'(2));
    check("rr_countB", 64'(countB), 64'(2));
`endif

    // Accept B, then stall with A waiting.
    step();
    inBValid = 1'b1; inB = 32'h0000_0002;
    @(negedge Clk);
    check("st_inBReady", 64'(inBReady), 64'(1));
    sb.push_back({1'b1, 32'h0000_0002});
    step();
    inBValid = 1'b0; inAValid = 1'b1; inA = 32'hA5A5_0003; outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("st_inAReady", 64'(inAReady), 64'(0));
      check("st_hold", 64'({outValid, sel, out}), 64'({2'b11, 32'h0000_0002}));
      step();
    end
    outReady = 1'b1;
    @(negedge Clk);
    check("st_release", 64'(inAReady), 64'(1));
    sb.push_back({1'b0, 32'hA5A5_0003});
    step();
    inAValid = 1'b0;
    @(negedge Clk);
    check("st_out", 64'(out), 64'(32'hA5A5_0003));

    // Drain with no refill.
    step();
    @(negedge Clk);
    check("dr_outValid", 64'(outValid), 64'(0));
    check("dr_out", 64'({sel, out}), 64'({1'b0, 32'hA5A5_0003}));

    // Five A words: wide counter reaches 5, narrow counter saturates at 3.
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inAValid = 1'b1; inA = 32'h0000_0100 + 32'(i); outReady = 1'b1;
      @(negedge Clk);
      check("sat_inAReady", 64'(inAReady), 64'(1));
      sb.push_back({1'b0, 32'h0000_0100 + 32'(i)});
      step();
      inAValid = 1'b0;
      if (i == 4) outReady = 1'b0;
      @(negedge Clk);
      check("sat_countA", 64'(s_countA), 64'((i < 3) ? i + 1 : 3));
      if (i < 4) step();
    end
    check("mid_countA", 64'(countA), 64'(5));
    check("mid_outValid", 64'(outValid), 64'(1));

    // Reset while a word is held and B is waiting.
    step();
    inBValid = 1'b1; inB = 32'h0000_000B; Reset = 1'b1;
    @(negedge Clk);
    check("mr_inBReady_rst", 64'(inBReady), 64'(0));
    step();
    void'(sb.pop_back());
    Reset = 1'b0;
    @(negedge Clk);
    check("mr_outValid", 64'(outValid), 64'(0));
    check("mr_countA", 64'(countA), 64'(0));
    check("mr_inBReady", 64'(inBReady), 64'(1));
    sb.push_back({1'b1, 32'h0000_000B});
    step();
    inBValid = 1'b0; outReady = 1'b1;
    @(negedge Clk);
    check("mr_countB", 64'(countB), 64'(1));
    step();
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux32_share_arbiter.md
Name: mux32_share_arbiter

Overview:
- Shares one 32-bit 2:1 mux path and its downstream consumer between two requesters, A and B.
- Each requester has a valid/ready handshake.
- Chooses the winner each cycle and drives the mux select.
- Registers the selected word into a one-entry output stage with its own valid/ready handshake.
- Keeps saturating per-requester transfer counts for debug and performance checks.

Parameters:
- WIDTH, 32, data width of both inputs and the output.
- CNT_W, 16, width of each saturating transfer counter.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- inAValid  input  1  requester A presents a word.
- inA  input  WIDTH  requester A data.
- inAReady  output  1  A's word is accepted this cycle.
- inBValid  input  1  requester B presents a word.
- inB  input  WIDTH  requester B data.
- inBReady  output  1  B's word is accepted this cycle.
- sel  output  1  registered mux select of the held word: 0 = A, 1 = B.
- outValid  output  1  output register holds a word.
- out  output  WIDTH  output register data.
- outReady  input  1  consumer takes the word this cycle.
- countA  output  CNT_W  accepted A transfers, saturating.
- countB  output  CNT_W  accepted B transfers, saturating.

Behaviour:
- Reset (sampled at the clock edge) sets:
  - outValid=0, out=0, sel=0, countA=0, countB=0;
  - internal lastGrant=1, so A wins the first tie.
- inAReady and inBReady are 0 in any cycle where Reset=1.
- canAccept = !outValid | outReady.
- Grant (combinational, evaluated every cycle):
  - only inAValid set -> grant A;
  - only inBValid set -> grant B;
  - both set -> grant the requester that is not lastGrant (round-robin);
  - neither set -> no grant.
- inAReady = canAccept & grantA; inBReady = canAccept & grantB. At most one ready is high in any cycle.
- Readies do not depend combinationally on the requesters' own valid beyond the grant rule. Requesters must not drop valid or change data until they see ready.
- Accept edge (canAccept & any grant):
  - out <= selected data (inA when grant A, inB when grant B);
  - sel <= granted id; outValid <= 1; lastGrant <= granted id;
  - the granted requester's counter increments.
- Latency: a word accepted at edge N is visible on out/outValid after edge N. Minimum 1 cycle input to output.
- Drain without refill (outValid & outReady, no grant): outValid <= 0 next cycle. out and sel hold their last values.
- Simultaneous drain and refill: the new word replaces the old in the same edge and outValid stays 1. Full throughput is 1 word per cycle.
- Stall (outValid & !outReady): out, sel and outValid hold; both readies are 0; lastGrant holds.
- Round-robin fairness: with both requesters continuously valid and outReady=1, grants alternate A, B, A, B... from reset.
- Counters: saturate at 2^CNT_W-1 and do not wrap. They reset only via Reset.
- Reset mid-operation: the held word is discarded (outValid=0) and counters clear. A requester still asserting valid is re-arbitrated from the reset state on the first cycle after Reset falls.

Optional Feature:
- Macro: MUX32_ARB_FIXED_PRIORITY_EN.
- Defined: on a tie, A always wins. lastGrant is unused for arbitration but still tracks the last grant. B is served only when A is not valid.
- Undefined: round-robin tie-break as described above.

Test Plan:
- Reset, then inAValid=1, inA=32'h00000001, outReady=1 -> inAReady=1.
  - Next cycle: out=32'h00000001, sel=0, outValid=1, countA=1.
- Both valid every cycle: A=32'hF0000001, B=32'hF0000002, outReady=1, for 4 cycles.
  - out sequence: F0000001, F0000002, F0000001, F0000002; sel 0,1,0,1; countA=2, countB=2.
  - With MUX32_ARB_FIXED_PRIORITY_EN defined: out=F0000001 all 4 cycles, countB=0.
- Accept B=32'h00000002, then outReady=0 for 3 cycles with A valid.
  - out stays 32'h00000002, sel=1, inAReady=0 throughout.
  - On outReady=1: A accepted the same cycle; out=A's word next cycle.
- Word held, outReady=1, no requester valid -> outValid=0 next cycle; out unchanged.
- Reset asserted for 1 cycle while outValid=1, countA=5, inBValid=1 -> next cycle outValid=0, countA=0, inBReady=0.
  - Cycle after Reset falls: inBReady=1.
- Build with CNT_W=2; send 5 A words -> countA sequence 1,2,3,3,3 (saturates, no wrap).
